// File: rtl/fetch_queue_ctrl_pkg.sv
// Shared widths, reset defaults and the queue entry layout for the fetch front end.
package fetch_pkg;
  localparam int              XLEN_DEFAULT     = 32;
  localparam int              INSTR_W          = 32;
  localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0]     PC_LIMIT_DEFAULT = 32'h0000_008C;

  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Request/response handshake between the fetch controller and the instruction cache.
interface fetch_queue_ctrl_if #(parameter int XLEN = 32);
  import fetch_pkg::*;

  logic               fetch_enable;
  logic [XLEN-1:0]    fetch_pc;
  logic               fetch_valid;
  logic [INSTR_W-1:0] instr_fetch;

  modport master (output fetch_enable, fetch_pc, input fetch_valid, instr_fetch);
  modport slave  (input fetch_enable, fetch_pc, output fetch_valid, instr_fetch);
endinterface

// File: rtl/fetch_queue_ctrl_fifo.sv
// Synchronous instruction queue; flush empties it in one edge, head is registered (no bypass).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          resetn,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  input  logic          flush,
  output entry_t        dout,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch front end: credit-limited icache requests, in-order response queue, redirect flush.
module fetch_queue_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter logic [XLEN-1:0] PC_LIMIT = XLEN'(PC_LIMIT_DEFAULT),
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               resetn,
  fetch_queue_ctrl_if.master ic,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               decoder_stall,
  input  logic               stall_debug,
  input  logic               we_reg_controller,
  output logic [INSTR_W-1:0] instr_fetch_exec,
  output logic               fetch_valid_exec,
  output logic [XLEN-1:0]    PC,
  output logic [XLEN-1:0]    nextPC,
  output logic               stall_pc,
  output logic               we_reg,
  output logic [CW-1:0]      occupancy
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } qentry_t;

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW:0]     credit_used;
  logic            fetch_go;
  logic            enq;
  logic            drop_stale;
  logic            pop;
  qentry_t         enq_entry;
  qentry_t         head;

  // Queue slots plus requests in flight never exceed DEPTH, so a push can never overflow.
  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
  assign fetch_go    = resetn && (credit_used < (CW+1)'(DEPTH)) &&
                       (fetch_pc_q <= PC_LIMIT) && !redirect_valid;

  assign drop_stale  = ic.fetch_valid && (discard != '0);
  assign enq         = ic.fetch_valid && (discard == '0) && !redirect_valid;
  assign enq_entry   = '{instr: ic.instr_fetch, pc: resp_pc_q};

  assign ic.fetch_enable = fetch_go;
  assign ic.fetch_pc     = fetch_pc_q;

  assign fetch_valid_exec = (occupancy != '0);
  assign stall_pc         = !fetch_valid_exec || decoder_stall || stall_debug;
  assign pop              = fetch_valid_exec && !stall_pc;
  assign we_reg           = we_reg_controller && !stall_pc;
  assign instr_fetch_exec = head.instr;
  assign PC               = fetch_valid_exec ? head.pc : resp_pc_q;
  assign nextPC           = PC + XLEN'(4);

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (qentry_t)
  ) u_fifo (
    .CLK    (CLK),
    .resetn (resetn),
    .push   (enq),
    .din    (enq_entry),
    .pop    (pop),
    .flush  (redirect_valid),
    .dout   (head),
    .count  (occupancy)
  );

  // Responses still in flight at a redirect are stale; discard counts them out as they arrive.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(fetch_go) - CW'(ic.fetch_valid);
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        resp_pc_q  <= redirect_pc;
        discard    <= outstanding - CW'(ic.fetch_valid);
      end else begin
        if (fetch_go)   fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (enq)        resp_pc_q  <= resp_pc_q + XLEN'(4);
        if (drop_stale) discard    <= discard - CW'(1);
      end
    end
  end

  // The icache only answers requests that were actually issued.
  always @(posedge CLK)
    if (resetn && ic.fetch_valid) assert (outstanding != '0);

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed checks on the default fetch queue plus a randomized DEPTH=4/XLEN=64 stream check.
module tb_fetch_queue_ctrl;
  import fetch_pkg::*;

  logic CLK = 1'b0;
  logic resetn = 1'b0;
  always #5 CLK = ~CLK;

  fetch_queue_ctrl_if #(.XLEN(32)) ic0 ();
  fetch_queue_ctrl_if #(.XLEN(64)) ic1 ();

  logic        redirect_valid0, decoder_stall0, stall_debug0, we_ctl0;
  logic [31:0] redirect_pc0;
  logic [31:0] instr_exec0, pc0, npc0;
  logic        fve0, stall_pc0, we_reg0;
  logic [1:0]  occ0;

  logic        redirect_valid1, decoder_stall1, stall_debug1, we_ctl1;
  logic [63:0] redirect_pc1;
  logic [31:0] instr_exec1;
  logic [63:0] pc1, npc1;
  logic        fve1, stall_pc1, we_reg1;
  logic [2:0]  occ1;

  fetch_queue_ctrl u0 (
    .CLK(CLK), .resetn(resetn), .ic(ic0),
    .redirect_valid(redirect_valid0), .redirect_pc(redirect_pc0),
    .decoder_stall(decoder_stall0), .stall_debug(stall_debug0), .we_reg_controller(we_ctl0),
    .instr_fetch_exec(instr_exec0), .fetch_valid_exec(fve0), .PC(pc0), .nextPC(npc0),
    .stall_pc(stall_pc0), .we_reg(we_reg0), .occupancy(occ0)
  );

  fetch_queue_ctrl #(.XLEN(64), .DEPTH(4), .PC_LIMIT(64'h3FC)) u1 (
    .CLK(CLK), .resetn(resetn), .ic(ic1),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
    .decoder_stall(decoder_stall1), .stall_debug(stall_debug1), .we_reg_controller(we_ctl1),
    .instr_fetch_exec(instr_exec1), .fetch_valid_exec(fve1), .PC(pc1), .nextPC(npc1),
    .stall_pc(stall_pc1), .we_reg(we_reg1), .occupancy(occ1)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] imem(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1357_9BDF;
  endfunction

  // icache models: in-order, answer head request unless held; latency >= 1 cycle
  logic [31:0] q0[$];
  logic [31:0] req0[$];
  logic [63:0] q1[$];
  bit hold0 = 1'b0;
  bit hold1 = 1'b0;

  always @(negedge CLK) begin
    if (!resetn) q0.delete();
    else begin
      if (ic0.fetch_valid) void'(q0.pop_front());
      if (ic0.fetch_enable) begin
        q0.push_back(ic0.fetch_pc);
        req0.push_back(ic0.fetch_pc);
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (!resetn || q0.size() == 0 || hold0) begin
      ic0.fetch_valid = 1'b0;
      ic0.instr_fetch = '0;
    end else begin
      ic0.fetch_valid = 1'b1;
      ic0.instr_fetch = imem({32'h0, q0[0]});
    end
  end

  always @(negedge CLK) begin
    if (!resetn) q1.delete();
    else begin
      if (ic1.fetch_valid) void'(q1.pop_front());
      if (ic1.fetch_enable) q1.push_back(ic1.fetch_pc);
    end
  end

  always @(posedge CLK) begin
    #1;
    if (!resetn || q1.size() == 0 || hold1) begin
      ic1.fetch_valid = 1'b0;
      ic1.instr_fetch = '0;
    end else begin
      ic1.fetch_valid = 1'b1;
      ic1.instr_fetch = imem(q1[0]);
    end
  end

  // retirement logs
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int          cyc;
  } ret_t;
  ret_t log0[$];
  int cyc = 0;

  always @(posedge CLK) begin
    if (!resetn) cyc = 0;
    else cyc++;
  end

  always @(negedge CLK)
    if (resetn && fve0 && !stall_pc0) log0.push_back('{pc0, instr_exec0, cyc});

  logic [63:0] exp_pc1;
  int n1 = 0;
  int err1 = 0;

  always @(negedge CLK) begin
    if (!resetn) begin
      exp_pc1 = '0;
      n1 = 0;
      err1 = 0;
    end else if (fve1 && !stall_pc1) begin
      if (pc1 !== exp_pc1 || instr_exec1 !== imem(exp_pc1) || we_reg1 !== we_ctl1) err1++;
      exp_pc1 += 64'd4;
      n1++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    redirect_valid0 = 1'b0; redirect_pc0 = '0; decoder_stall0 = 1'b0; stall_debug0 = 1'b0;
    we_ctl0 = 1'b1; hold0 = 1'b0;
    redirect_valid1 = 1'b0; redirect_pc1 = '0; decoder_stall1 = 1'b0; stall_debug1 = 1'b0;
    we_ctl1 = 1'b1; hold1 = 1'b0;
    step(2);
    log0.delete();
    req0.delete();
    resetn = 1'b1;
  endtask

  int e;

  initial begin
    // reset values
    do_reset();
    resetn = 1'b0;
    step(1);
    @(negedge CLK);
    chk("rst_fve", fve0, 0);
    chk("rst_stall", stall_pc0, 1);
    chk("rst_we", we_reg0, 0);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_npc", npc0, 32'h4);
    chk("rst_fe", ic0.fetch_enable, 0);
    chk("rst_occ", occ0, 0);

    // A: streaming, 1-cycle icache
    do_reset();
    @(negedge CLK);
    chk("A_fe0", ic0.fetch_enable, 1);
    chk("A_fpc0", ic0.fetch_pc, 32'h0);
    step(9);
    chk("A_nret", log0.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      chk("A_pc", log0[i].pc, 32'(i * 4));
      chk("A_ins", log0[i].ins, imem(64'(i * 4)));
    end
    chk("A_cyc0", log0[0].cyc, 2);
    chk("A_cyc1", log0[1].cyc, 3);
    for (int i = 0; i < 4; i++) chk("A_req", req0[i], 32'(i * 4));

    // B: decoder stall saturates the queue
    do_reset();
    decoder_stall0 = 1'b1;
    step(4);
    @(negedge CLK);
    chk("B_occ", occ0, 2);
    chk("B_fe", ic0.fetch_enable, 0);
    chk("B_we", we_reg0, 0);
    chk("B_stall", stall_pc0, 1);
    step(1);
    decoder_stall0 = 1'b0;
    stall_debug0 = 1'b1;
    @(negedge CLK);
    chk("B_dbg_stall", stall_pc0, 1);
    chk("B_dbg_we", we_reg0, 0);
    chk("B_dbg_occ", occ0, 2);
    step(1);
    stall_debug0 = 1'b0;
    step(15);
    chk("B_nret", log0.size() >= 6, 1);
    chk("B_cyc0", log0[0].cyc, 6);
    for (int i = 0; i < 6; i++) begin
      chk("B_pc", log0[i].pc, 32'(i * 4));
      chk("B_ins", log0[i].ins, imem(64'(i * 4)));
    end

    // C: redirect with two requests outstanding
    do_reset();
    hold0 = 1'b1;
    step(2);
    redirect_valid0 = 1'b1;
    redirect_pc0 = 32'h40;
    hold0 = 1'b0;
    @(negedge CLK);
    chk("C_fe_redir", ic0.fetch_enable, 0);
    step(1);
    redirect_valid0 = 1'b0;
    @(negedge CLK);
    chk("C_occ", occ0, 0);
    chk("C_fpc", ic0.fetch_pc, 32'h40);
    chk("C_fe_wait", ic0.fetch_enable, 0);
    step(12);
    chk("C_pc", log0[0].pc, 32'h40);
    chk("C_ins", log0[0].ins, imem(64'h40));

    // D: redirect coincident with response and pop
    do_reset();
    step(2);
    redirect_valid0 = 1'b1;
    redirect_pc0 = 32'h20;
    @(negedge CLK);
    chk("D_fv_in", ic0.fetch_valid, 1);
    chk("D_stall", stall_pc0, 0);
    chk("D_we", we_reg0, 1);
    chk("D_head", pc0, 32'h0);
    step(1);
    redirect_valid0 = 1'b0;
    @(negedge CLK);
    chk("D_occ", occ0, 0);
    chk("D_fve", fve0, 0);
    chk("D_fe", ic0.fetch_enable, 1);
    chk("D_fpc", ic0.fetch_pc, 32'h20);
    step(6);
    chk("D_ret0", log0[0].pc, 32'h0);
    chk("D_ret1", log0[1].pc, 32'h20);
    chk("D_ins1", log0[1].ins, imem(64'h20));

    // E: run to PC_LIMIT, resume by redirect, then redirect past the limit
    do_reset();
    step(80);
    @(negedge CLK);
    chk("E_nret", log0.size(), 36);
    chk("E_last", log0[35].pc, 32'h8C);
    e = 0;
    foreach (log0[i])
      if (log0[i].pc !== 32'(i * 4) || log0[i].ins !== imem(64'(i * 4))) e++;
    chk("E_seq", e, 0);
    chk("E_fe", ic0.fetch_enable, 0);
    chk("E_fpc", ic0.fetch_pc, 32'h90);
    step(1);
    redirect_valid0 = 1'b1;
    redirect_pc0 = 32'h10;
    step(1);
    redirect_valid0 = 1'b0;
    step(10);
    chk("E_resume", log0[36].pc, 32'h10);
    chk("E_resume_ins", log0[36].ins, imem(64'h10));
    redirect_valid0 = 1'b1;
    redirect_pc0 = 32'hFFFF_FFFC;
    step(1);
    redirect_valid0 = 1'b0;
    step(4);
    @(negedge CLK);
    chk("E_halt_fe", ic0.fetch_enable, 0);
    chk("E_halt_occ", occ0, 0);
    chk("E_halt_pc", pc0, 32'hFFFF_FFFC);
    chk("E_wrap_npc", npc0, 32'h0);

    // F: DEPTH=4, XLEN=64 with random icache latency and stalls
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(1);
      hold1 = ($urandom_range(0, 2) == 0);
      decoder_stall1 = ($urandom_range(0, 3) == 0);
      stall_debug1 = ($urandom_range(0, 15) == 0);
      we_ctl1 = $urandom_range(0, 1) == 1;
    end
    hold1 = 1'b0;
    decoder_stall1 = 1'b0;
    stall_debug1 = 1'b0;
    step(20);
    chk("F_err", err1, 0);
    chk("F_cnt", n1, 256);
    chk("F_fe", ic1.fetch_enable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
